cpu_fsm: RTL and testbench

Controller state machine for the lab CPU. It takes the decoded `opcode`/`op` fields from the instruction decoder and the `s` start strobe. It sequences the register-file/ALU datapath through read, execute and write-back steps, driving every datapath control line, and reports idle via `w`. It sits between the instruction decoder and the datapath inside `cpu`.

---
 rtl/cpu_fsm.sv | 161 ++++++++++++++++
 tb/tb_cpu_fsm.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_fsm.sv
`timescale 1ns / 1ps
// cpu_fsm: controller for the lab CPU. It sequences the register-file/ALU
// datapath through read, execute and write-back steps for the decoded
// instruction. The idle indication is `w`. All outputs are registered
// Moore outputs, computed from the state being entered.
module cpu_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic       s,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       w,
  output logic [2:0] nsel,
  output logic [1:0] vsel,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic       write
);

  // One-hot register selects and write-back sources.
  localparam logic [2:0] NselNone = 3'b000;
  localparam logic [2:0] NselRn   = 3'b100;
  localparam logic [2:0] NselRd   = 3'b010;
  localparam logic [2:0] NselRm   = 3'b001;
  localparam logic [1:0] VselC    = 2'b00;
  localparam logic [1:0] VselImm8 = 2'b10;

  typedef enum logic [2:0] {
    StWait,
    StDecode,
    StWriteImm,
    StGetA,
    StGetB,
    StAlu,
    StWriteReg
  } state_e;

  // Zero is the illegal class, so the reset value of the class register is 0.
  typedef enum logic [2:0] {
    ClsIllegal = 3'd0,
    ClsMovImm  = 3'd1,
    ClsMovReg  = 3'd2,
    ClsAdd     = 3'd3,
    ClsCmp     = 3'd4,
    ClsAnd     = 3'd5,
    ClsMvn     = 3'd6
  } class_e;

  state_e state, state_next;
  class_e cls, cls_dec;

  // Classify the decoder fields; anything not listed is illegal.
  always_comb begin
    cls_dec = ClsIllegal;
    case ({opcode, op})
      5'b110_10: cls_dec = ClsMovImm;
      5'b110_00: cls_dec = ClsMovReg;
      5'b101_00: cls_dec = ClsAdd;
      5'b101_01: cls_dec = ClsCmp;
      5'b101_10: cls_dec = ClsAnd;
      5'b101_11: cls_dec = ClsMvn;
      default:   cls_dec = ClsIllegal;
    endcase
  end

  // Next-state selection. After DECODE only the captured class is used.
  always_comb begin
    state_next = state;
    case (state)
      StWait: begin
        if (s) state_next = StDecode;
      end
      StDecode: begin
        case (cls_dec)
          ClsMovImm:                 state_next = StWriteImm;
          ClsAdd, ClsCmp, ClsAnd:    state_next = StGetA;
          ClsMovReg, ClsMvn:         state_next = StGetB;
          default:                   state_next = StWait;
        endcase
      end
      StWriteImm: state_next = StWait;
      StGetA:     state_next = StGetB;
      StGetB:     state_next = StAlu;
      StAlu: begin
        if (cls == ClsCmp) state_next = StWait;
        else               state_next = StWriteReg;
      end
      StWriteReg: state_next = StWait;
      default:    state_next = StWait;
    endcase
  end

  // State, captured class and registered Moore outputs for the state being
  // entered. Reset clears everything asynchronously, so a pending write or
  // load drops the moment reset rises.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= StWait;
      cls   <= ClsIllegal;
      w     <= 1'b1;
      nsel  <= NselNone;
      vsel  <= VselC;
      loada <= 1'b0;
      loadb <= 1'b0;
      loadc <= 1'b0;
      loads <= 1'b0;
      asel  <= 1'b0;
      bsel  <= 1'b0;
      write <= 1'b0;
    end else begin
      state <= state_next;
      if (state == StDecode) cls <= cls_dec;

      w     <= 1'b0;
      nsel  <= NselNone;
      vsel  <= VselC;
      loada <= 1'b0;
      loadb <= 1'b0;
      loadc <= 1'b0;
      loads <= 1'b0;
      asel  <= 1'b0;
      bsel  <= 1'b0;
      write <= 1'b0;

      case (state_next)
        StWait: w <= 1'b1;
        StWriteImm: begin
          nsel  <= NselRn;
          vsel  <= VselImm8;
          write <= 1'b1;
        end
        StGetA: begin
          nsel  <= NselRn;
          loada <= 1'b1;
        end
        StGetB: begin
          nsel  <= NselRm;
          loadb <= 1'b1;
        end
        StAlu: begin
          // ALU is only entered from GET_B, so cls already holds the class.
          // MOV reg and MVN zero the A operand; MOV reg then adds 0 + shifted Rm.
          asel <= (cls == ClsMovReg) || (cls == ClsMvn);
          if (cls == ClsCmp) loads <= 1'b1;
          else               loadc <= 1'b1;
        end
        StWriteReg: begin
          nsel  <= NselRd;
          vsel  <= VselC;
          write <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_fsm.sv
`timescale 1ns / 1ps
// Scoreboard bench for cpu_fsm: the stimulus side pushes the expected
// per-cycle output trace of each instruction; a monitor pops and compares
// every cycle, and expects the idle pattern whenever nothing is queued.
module tb_cpu_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       s;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       w, loada, loadb, loadc, loads, asel, bsel, write;
  logic [2:0] nsel;
  logic [1:0] vsel;

  cpu_fsm dut (
    .clk    (clk),
    .reset  (reset),
    .s      (s),
    .opcode (opcode),
    .op     (op),
    .w      (w),
    .nsel   (nsel),
    .vsel   (vsel),
    .loada  (loada),
    .loadb  (loadb),
    .loadc  (loadc),
    .loads  (loads),
    .asel   (asel),
    .bsel   (bsel),
    .write  (write)
  );

  always #5 clk = ~clk;

  // Output word: {w, nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write}
  logic [12:0] dut_out;
  assign dut_out = {w, nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write};

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;
  logic [12:0] exp_q[$];

  function automatic logic [12:0] mk(input logic wv, input logic [2:0] n, input logic [1:0] v,
                                     input logic la, input logic lb, input logic lc,
                                     input logic ls, input logic as, input logic wr);
    return {wv, n, v, la, lb, lc, ls, as, 1'b0, wr};
  endfunction

  task automatic chk(input string name, input logic [12:0] got, input logic [12:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%b expected=%b", name, cyc, got, want);
    end
  endtask

  // Reference model: expected outputs from the WAIT cycle in which s is
  // sampled through the last busy cycle; the following cycle is WAIT again.
  task automatic push_trace(input logic [4:0] code);
    bit mov_imm, mov_reg, add, cmp, and_op, mvn, uses_rn;
    mov_imm = (code == 5'b110_10);
    mov_reg = (code == 5'b110_00);
    add     = (code == 5'b101_00);
    cmp     = (code == 5'b101_01);
    and_op  = (code == 5'b101_10);
    mvn     = (code == 5'b101_11);
    uses_rn = add || cmp || and_op;
    exp_q.push_back(mk(1, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0));   // WAIT, s sampled
    exp_q.push_back(mk(0, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0));   // DECODE
    if (mov_imm) begin
      exp_q.push_back(mk(0, 3'b100, 2'b10, 0, 0, 0, 0, 0, 1));
    end else if (uses_rn || mov_reg || mvn) begin
      if (uses_rn) exp_q.push_back(mk(0, 3'b100, 2'b00, 1, 0, 0, 0, 0, 0));
      exp_q.push_back(mk(0, 3'b001, 2'b00, 0, 1, 0, 0, 0, 0));
      exp_q.push_back(mk(0, 3'b000, 2'b00, 0, 0, !cmp, cmp, !uses_rn, 0));
      if (!cmp) exp_q.push_back(mk(0, 3'b010, 2'b00, 0, 0, 0, 0, 0, 1));
    end
  endtask

  // Monitor: sample on the falling edge, away from the active edge.
  always @(negedge clk) begin
    logic [12:0] e;
    cyc++;
    if (mon_en) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("trace", dut_out, e);
      end else begin
        chk("idle", dut_out, mk(1, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0));
      end
    end
  end

  // Called in a WAIT cycle; returns in the next WAIT cycle. Inputs wander
  // randomly once the class has been captured; corrupt forces MOV imm.
  task automatic issue(input logic [4:0] code, input bit corrupt);
    int n0, len;
    n0 = exp_q.size();
    push_trace(code);
    len = exp_q.size() - n0;
    s = 1'b1;
    {opcode, op} = code;
    for (int i = 1; i <= len; i++) begin
      @(posedge clk);
      #1;
      if (i == len) s = 1'b0;
      else          s = 1'($urandom);
      if (i >= 2) begin
        if (corrupt) {opcode, op} = 5'b110_10;
        else         {opcode, op} = 5'($urandom);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      s = 1'b0;
      {opcode, op} = 5'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [4:0] rand_code();
    logic [4:0] legal [6];
    legal[0] = 5'b110_10; legal[1] = 5'b110_00; legal[2] = 5'b101_00;
    legal[3] = 5'b101_01; legal[4] = 5'b101_10; legal[5] = 5'b101_11;
    if ($urandom_range(0, 3) == 0) return 5'($urandom);
    return legal[$urandom_range(0, 5)];
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog cycle=%0d got=running expected=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    s = 1'b0;
    {opcode, op} = 5'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_value", dut_out, mk(1, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0));
    reset = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    idle(3);

    // Directed: one of each class, illegal, and AND with the decoder
    // fields flipped to MOV imm after DECODE.
    issue(5'b110_10, 1'b0);
    idle(2);
    issue(5'b101_00, 1'b0);
    idle(1);
    issue(5'b101_01, 1'b0);
    idle(1);
    issue(5'b101_11, 1'b0);
    idle(1);
    issue(5'b110_00, 1'b0);
    idle(1);
    issue(5'b111_11, 1'b0);
    idle(1);
    issue(5'b101_10, 1'b1);
    idle(1);

    // Reset during GET_B of an ADD.
    push_trace(5'b101_00);
    s = 1'b1;
    {opcode, op} = 5'b101_00;
    @(posedge clk); #1; s = 1'b0;      // DECODE
    @(posedge clk); #1;                // GET_A
    @(posedge clk); #1;                // GET_B
    mon_en = 1'b0;
    reset = 1'b1;
    #1;
    chk("reset_abort_w", {12'b0, w}, 13'd1);
    chk("reset_abort_write", {12'b0, write}, 13'd0);
    chk("reset_abort_loads", {10'b0, loada, loadb, loadc}, 13'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    idle(5);

    // s held high: back-to-back instructions, one WAIT cycle between.
    issue(5'b101_00, 1'b0);
    issue(5'b110_10, 1'b0);
    issue(5'b101_01, 1'b0);
    issue(5'b111_11, 1'b0);
    issue(5'b110_00, 1'b0);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      issue(rand_code(), 1'($urandom_range(0, 7) == 0));
    end
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
